// File: rtl/dac_spi_tx_if.sv
// Sample/strobe input and DAC serial-link/status signals of the serial DAC transmitter.
interface dac_spi_tx_if;
  localparam int unsigned DW = 12;

  logic          st;
  logic [DW-1:0] DI;
  logic          SCLK;
  logic          SYNC;
  logic          SDO;
  logic          BUSY;
  logic          DONE;
  logic          OVR;

  modport master (output st, DI, input SCLK, SYNC, SDO, BUSY, DONE, OVR);
  modport slave  (input st, DI, output SCLK, SYNC, SDO, BUSY, DONE, OVR);
endinterface

// File: rtl/dac_spi_tx.sv
// Shifts {CTRL, DI} MSB-first to a serial DAC over SCLK/SYNC/SDO, one frame per accepted strobe.
module dac_spi_tx #(
  parameter int unsigned F_DIV = 4,
  parameter logic [3:0]  CTRL  = 4'b0000
) (
  input logic         clk,
  input logic         rst,
  dac_spi_tx_if.slave bus
);

  localparam int unsigned FW = 16;
  localparam int unsigned HW = 8;
  localparam int unsigned BW = 4;
  localparam int unsigned TW = 5;

  localparam logic [HW-1:0] HP_TC   = HW'(F_DIV - 1);
  localparam logic [BW-1:0] BIT_TC  = BW'(FW - 1);
  localparam logic [TW-1:0] TOG_TC  = TW'(2 * FW - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic            sclk_q, sclk_d;
  logic [FW-1:0]   shreg_q, shreg_d;
  logic [HW-1:0]   hp_q, hp_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [TW-1:0]   tog_q, tog_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;

  // State register; rst aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sclk_q  <= 1'b1;
      shreg_q <= '0;
      hp_q    <= '0;
      bit_q   <= '0;
      tog_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      shreg_q <= shreg_d;
      hp_q    <= hp_d;
      bit_q   <= bit_d;
      tog_q   <= tog_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: half-period divider drives SCLK toggles; shift happens on rising toggles
  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    shreg_d = shreg_q;
    hp_d    = hp_q;
    bit_d   = bit_q;
    tog_d   = tog_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        if (bus.st) begin
          state_d = SHIFT;
          shreg_d = {CTRL, bus.DI};
          hp_d    = '0;
          bit_d   = '0;
          tog_d   = '0;
        end
      end
      SHIFT: begin
        if (bus.st) begin
          ovr_d = 1'b1;
        end
        if (hp_q == HP_TC) begin
          hp_d   = '0;
          sclk_d = ~sclk_q;
          tog_d  = tog_q + TW'(1);
          if (!sclk_q) begin
            // The last rising edge leaves the register untouched
            if (bit_q != BIT_TC) begin
              shreg_d = {shreg_q[FW-2:0], 1'b0};
            end
            bit_d = bit_q + BW'(1);
          end
          if (tog_q == TOG_TC) begin
            state_d = IDLE;
            sclk_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          hp_d = hp_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.SCLK = sclk_q;
  assign bus.SYNC = (state_q == IDLE);
  assign bus.SDO  = shreg_q[FW-1];
  assign bus.BUSY = (state_q == SHIFT);
  assign bus.DONE = done_q;
  assign bus.OVR  = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: one instance at F_DIV=4/CTRL=0, one at F_DIV=1/CTRL=4'b1001.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic [11:0] di_v;
  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  dac_spi_tx_if if4();
  dac_spi_tx_if if1();

  dac_spi_tx #(.F_DIV(4), .CTRL(4'b0000)) u_f4 (.clk(clk), .rst(rst), .bus(if4));
  dac_spi_tx #(.F_DIV(1), .CTRL(4'b1001)) u_f1 (.clk(clk), .rst(rst), .bus(if1));

  logic o_sclk, o_sync, o_sdo, o_busy, o_done, o_ovr;
  assign o_sclk = sel ? if1.SCLK : if4.SCLK;
  assign o_sync = sel ? if1.SYNC : if4.SYNC;
  assign o_sdo  = sel ? if1.SDO  : if4.SDO;
  assign o_busy = sel ? if1.BUSY : if4.BUSY;
  assign o_done = sel ? if1.DONE : if4.DONE;
  assign o_ovr  = sel ? if1.OVR  : if4.OVR;

  logic [15:0] w;
  int lw, dc, nd, nf, ff, nt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [11:0] d);
    di_v = d;
    if (sel) begin
      if1.st = s;
      if1.DI = d;
      if4.st = 1'b0;
    end else begin
      if4.st = s;
      if4.DI = d;
      if1.st = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called with st already driven high; follows the frame and captures SDO on every SCLK fall
  task automatic watch(input logic [15:0] expw, input int ovr_c, input int rst_c,
                       input int dich_c, input logic bb, input logic [11:0] bbdi,
                       input int limit, output logic [15:0] word, output int low,
                       output int done_c, output int ndone, output int nfall,
                       output int first_fall, output int ntog);
    logic prev;
    prev = 1'b1;
    word = '0;
    low = 0; done_c = 0; ndone = 0; nfall = 0; first_fall = 0; ntog = 0;
    for (int c = 1; c <= limit; c++) begin
      tick();
      if (c == 1) begin
        drive(1'b0, di_v);
        chk("first_sync", 32'(o_sync), 32'(0));
        chk("first_sclk", 32'(o_sclk), 32'(1));
        chk("first_busy", 32'(o_busy), 32'(1));
        chk("first_sdo",  32'(o_sdo),  32'(expw[15]));
        chk("done_width", 32'(o_done), 32'(0));
      end
      if (!o_sync) low++;
      if (o_sclk != prev) ntog++;
      if (prev && !o_sclk && !o_sync) begin
        nfall++;
        word = {word[14:0], o_sdo};
        if (first_fall == 0) first_fall = c;
      end
      prev = o_sclk;
      if (c == ovr_c) begin
        chk("ovr_before", 32'(o_ovr), 32'(0));
        drive(1'b1, 12'h555);
      end
      if (c == ovr_c + 1) begin
        drive(1'b0, di_v);
        chk("ovr_set", 32'(o_ovr), 32'(1));
      end
      if (c == dich_c) drive(1'b0, 12'h000);
      if (c == rst_c) rst = 1'b1;
      if (c == rst_c + 1) begin
        rst = 1'b0;
        chk("rst_sync", 32'(o_sync), 32'(1));
        chk("rst_sclk", 32'(o_sclk), 32'(1));
        chk("rst_busy", 32'(o_busy), 32'(0));
      end
      if (o_done) begin
        ndone++;
        if (done_c == 0) done_c = c;
        if (bb) drive(1'b1, bbdi);
        if (rst_c < 0) break;
      end
    end
  endtask

  initial begin
    sel  = 1'b0;
    di_v = '0;
    rst  = 1'b1;
    if4.st = 1'b0; if4.DI = '0;
    if1.st = 1'b0; if1.DI = '0;

    // Reset held three cycles under random stimulus
    for (int i = 0; i < 3; i++) begin
      if4.st = 1'($urandom); if4.DI = 12'($urandom);
      if1.st = 1'($urandom); if1.DI = 12'($urandom);
      tick();
    end
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #0;
      chk("rst_SCLK", 32'(o_sclk), 32'(1));
      chk("rst_SYNC", 32'(o_sync), 32'(1));
      chk("rst_SDO",  32'(o_sdo),  32'(0));
      chk("rst_BUSY", 32'(o_busy), 32'(0));
      chk("rst_DONE", 32'(o_done), 32'(0));
      chk("rst_OVR",  32'(o_ovr),  32'(0));
    end
    sel = 1'b0;
    if4.st = 1'b0; if1.st = 1'b0;
    rst = 1'b0;
    repeat (3) tick();

    // Frame 0ABC, followed by a back-to-back 0123 started in the DONE cycle
    drive(1'b1, 12'hABC);
    watch(16'h0ABC, -10, -10, -10, 1'b1, 12'h123, 300, w, lw, dc, nd, nf, ff, nt);
    chk("f1_word",  32'(w), 32'h0ABC);
    chk("f1_low",   32'(lw), 32'd128);
    chk("f1_done",  32'(dc), 32'd129);
    chk("f1_nfall", 32'(nf), 32'd16);
    chk("f1_lat",   32'(ff), 32'd5);
    chk("f1_ntog",  32'(nt), 32'd32);

    watch(16'h0123, -10, -10, -10, 1'b0, 12'h000, 300, w, lw, dc, nd, nf, ff, nt);
    chk("f2_word", 32'(w), 32'h0123);
    chk("f2_low",  32'(lw), 32'd128);
    chk("f2_done", 32'(dc), 32'd129);
    chk("f2_ovr",  32'(o_ovr), 32'(0));
    tick();
    chk("f2_done_gone", 32'(o_done), 32'(0));
    tick();

    // Overrun: second strobe mid-frame is ignored but flagged
    drive(1'b1, 12'hABC);
    watch(16'h0ABC, 40, -10, -10, 1'b0, 12'h000, 300, w, lw, dc, nd, nf, ff, nt);
    chk("f3_word", 32'(w), 32'h0ABC);
    chk("f3_done", 32'(dc), 32'd129);
    repeat (3) tick();
    chk("f3_ovr_sticky", 32'(o_ovr), 32'(1));

    // Reset mid-frame: no DONE, OVR cleared
    drive(1'b1, 12'h3C5);
    watch(16'h03C5, -10, 50, -10, 1'b0, 12'h000, 200, w, lw, dc, nd, nf, ff, nt);
    chk("f4_ndone", 32'(nd), 32'(0));
    chk("f4_ovr",   32'(o_ovr), 32'(0));

    // rst and st together: no frame starts
    rst = 1'b1;
    drive(1'b1, 12'hABC);
    tick();
    drive(1'b0, 12'hABC);
    rst = 1'b0;
    chk("rst_st_sync", 32'(o_sync), 32'(1));
    tick();
    chk("rst_st_busy", 32'(o_busy), 32'(0));

    // F_DIV=1 instance, DI changed mid-frame
    sel = 1'b1;
    tick();
    drive(1'b1, 12'hFFF);
    watch(16'h9FFF, -10, -10, 10, 1'b0, 12'h000, 60, w, lw, dc, nd, nf, ff, nt);
    chk("f5_word",  32'(w), 32'h9FFF);
    chk("f5_low",   32'(lw), 32'd32);
    chk("f5_done",  32'(dc), 32'd33);
    chk("f5_lat",   32'(ff), 32'd2);
    chk("f5_ntog",  32'(nt), 32'd32);
    chk("f5_nfall", 32'(nf), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
